bin_to_bcd: RTL and testbench



---
 rtl/bin_to_bcd_pkg.sv | 20 ++
 rtl/bin_to_bcd_digit_adj.sv | 18 +
 rtl/bin_to_bcd.sv | 181 ++++++++++++++++++
 tb/tb_bin_to_bcd.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the bin_to_bcd converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // Double-dabble digit correction: digits >= 5 get +3 before each shift.
  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

  // Widest legal operand (63 -> tens digit 6) and the bit-counter width it needs.
  localparam int unsigned MAX_WIDTH = 6;
  localparam int unsigned CNT_W     = 3;

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// Single BCD digit correction stage for double-dabble: adds 3 when the
// digit is 5 or more. 4-bit add, carry out discarded.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Conditional +3 correction.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_ADJ_THRESH) begin
      digit_o = digit_i + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Binary to two-digit BCD converter (tens, ones) using double-dabble.
// Default build: iterative, one bit per clock under START/DONE handshake.
// Define BIN2BCD_FAST_EN to replace the iterative datapath with a
// combinational double-dabble network (result one cycle after START,
// BUSY tied low).
module bin_to_bcd
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] VALUE,
  output logic [3:0]       TENS,
  output logic [3:0]       ONES,
  output logic             BUSY,
  output logic             DONE
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_chk
    $error("bin_to_bcd: WIDTH must be in the range 1..6");
  end

`ifdef BIN2BCD_FAST_EN

  logic [WIDTH-1:0]   val_q;
  logic               pend_q;
  bcd_digit_t         tens_q;
  bcd_digit_t         ones_q;
  logic               done_q;
  // Stage i holds the BCD field after the i-th shift of the unrolled network.
  logic [WIDTH:0][3:0] st_tens;
  logic [WIDTH:0][3:0] st_ones;

  assign st_tens[0] = '0;
  assign st_ones[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    bcd_digit_t adj_tens;
    bcd_digit_t adj_ones;

    bcd_digit_adj u_adj_tens (
      .digit_i (st_tens[i]),
      .digit_o (adj_tens)
    );

    bcd_digit_adj u_adj_ones (
      .digit_i (st_ones[i]),
      .digit_o (adj_ones)
    );

    // Shift left by one, pulling in the next operand bit MSB-first.
    assign st_tens[i+1] = {adj_tens[2:0], adj_ones[3]};
    assign st_ones[i+1] = {adj_ones[2:0], val_q[WIDTH-1-i]};
  end

  // Capture the operand on START, then register the converted digits one
  // cycle later together with the DONE pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      val_q  <= '0;
      pend_q <= 1'b0;
      tens_q <= '0;
      ones_q <= '0;
      done_q <= 1'b0;
    end else begin
      pend_q <= START;
      done_q <= pend_q;
      if (START) begin
        val_q <= VALUE;
      end
      if (pend_q) begin
        tens_q <= st_tens[WIDTH];
        ones_q <= st_ones[WIDTH];
      end
    end
  end

  assign TENS = tens_q;
  assign ONES = ones_q;
  assign BUSY = 1'b0;
  assign DONE = done_q;

`else

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bcd_digit_t       tens_q, tens_d;
  bcd_digit_t       ones_q, ones_d;
  logic             done_q, done_d;

  bcd_digit_t       adj_tens;
  bcd_digit_t       adj_ones;
  logic [WIDTH+7:0] shift_w;

  bcd_digit_adj u_adj_tens (
    .digit_i (bcd_q[7:4]),
    .digit_o (adj_tens)
  );

  bcd_digit_adj u_adj_ones (
    .digit_i (bcd_q[3:0]),
    .digit_o (adj_ones)
  );

  // Corrected {BCD, binary} field shifted left by one; the tens MSB falls
  // off, which is safe because tens never exceeds 6.
  always_comb begin
    shift_w = {adj_tens[2:0], adj_ones, bin_q, 1'b0};
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath control: load, WIDTH shifts, then publish.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          bin_d   = VALUE;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shift_w[WIDTH+7:WIDTH];
        bin_d = shift_w[WIDTH-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign TENS = tens_q;
  assign ONES = ones_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;

`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: a WIDTH=4 and a WIDTH=6 instance share
// START; each has its own reference model of acceptance, latency and result.
module tb_bin_to_bcd;

`ifdef BIN2BCD_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    int done_edge;
    int tens;
    int ones;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] value4;
  logic [5:0] value6;
  logic [3:0] tens_w [2];
  logic [3:0] ones_w [2];
  logic       busy_w [2];
  logic       done_w [2];

  int   wid [2] = '{4, 6};
  exp_t sb [2][$];
  int   free_edge [2] = '{0, 0};
  int   held_t [2] = '{0, 0};
  int   held_o [2] = '{0, 0};
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  bin_to_bcd #(.WIDTH(4)) u_dut4 (
    .CLK     (CLK),
    .RESET_N (rst_n),
    .START   (start),
    .VALUE   (value4),
    .TENS    (tens_w[0]),
    .ONES    (ones_w[0]),
    .BUSY    (busy_w[0]),
    .DONE    (done_w[0])
  );

  bin_to_bcd #(.WIDTH(6)) u_dut6 (
    .CLK     (CLK),
    .RESET_N (rst_n),
    .START   (start),
    .VALUE   (value6),
    .TENS    (tens_w[1]),
    .ONES    (ones_w[1]),
    .BUSY    (busy_w[1]),
    .DONE    (done_w[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_cnt, act, exp);
    end
  endtask

  function automatic int lat(input int d);
    return FAST ? 1 : wid[d] + 1;
  endfunction

  function automatic int per(input int d);
    return FAST ? 1 : wid[d] + 2;
  endfunction

  // Drive one cycle of stimulus; the model decides whether START is taken.
  task automatic step(input bit s, input logic [5:0] v);
    @(negedge CLK);
    start  = s;
    value4 = v[3:0];
    value6 = v;
    for (int d = 0; d < 2; d++) begin
      automatic int k   = edge_cnt + 1;
      automatic int val = (d == 0) ? int'(v[3:0]) : int'(v);
      if (s && rst_n && k >= free_edge[d]) begin
        sb[d].push_back('{k + lat(d), val / 10, val % 10});
        free_edge[d] = k + per(d);
      end
    end
  endtask

  // Asynchronous reset between clock edges, with an immediate output check.
  task automatic async_reset();
    @(negedge CLK);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_TENS", d), int'(tens_w[d]), 0);
      chk($sformatf("d%0d_rst_ONES", d), int'(ones_w[d]), 0);
      chk($sformatf("d%0d_rst_BUSY", d), int'(busy_w[d]), 0);
      chk($sformatf("d%0d_rst_DONE", d), int'(done_w[d]), 0);
      sb[d].delete();
      free_edge[d] = 0;
      held_t[d]    = 0;
      held_o[d]    = 0;
    end
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  // Monitor: after every edge, compare DONE/TENS/ONES/BUSY with the model.
  initial begin
    forever begin
      @(posedge CLK);
      edge_cnt++;
      #1;
      for (int d = 0; d < 2; d++) begin
        automatic int exp_done = 0;
        if (sb[d].size() > 0 && sb[d][0].done_edge == edge_cnt) begin
          exp_done  = 1;
          held_t[d] = sb[d][0].tens;
          held_o[d] = sb[d][0].ones;
          void'(sb[d].pop_front());
        end
        chk($sformatf("d%0d_DONE", d), int'(done_w[d]), exp_done);
        chk($sformatf("d%0d_TENS", d), int'(tens_w[d]), held_t[d]);
        chk($sformatf("d%0d_ONES", d), int'(ones_w[d]), held_o[d]);
        chk($sformatf("d%0d_BUSY", d), int'(busy_w[d]),
            (!FAST && (edge_cnt + 1 < free_edge[d])) ? 1 : 0);
      end
    end
  end

  initial begin
    int seq [4] = '{3, 10, 14, 11};
    int bnd [4] = '{0, 9, 15, 63};
    rst_n  = 1'b0;
    start  = 1'b0;
    value4 = '0;
    value6 = '0;
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;

    // Sequential conversions, each issued after the previous DONE.
    foreach (seq[i]) begin
      step(1'b1, 6'(seq[i]));
      repeat (9) step(1'b0, 6'd0);
    end

    // Boundary operands (63 also gives 15 on the 4-bit instance).
    foreach (bnd[i]) begin
      step(1'b1, 6'(bnd[i]));
      repeat (9) step(1'b0, 6'd0);
    end

    // START mid-conversion is ignored; 12 must stay visible afterwards.
    step(1'b1, 6'd12);
    repeat (2) step(1'b0, 6'd0);
    step(1'b1, 6'd7);
    repeat (12) step(1'b0, 6'd0);

    // Reset during SHIFT aborts the conversion; 13 then converts cleanly.
    step(1'b1, 6'd40);
    repeat (2) step(1'b0, 6'd0);
    async_reset();
    step(1'b1, 6'd13);
    repeat (9) step(1'b0, 6'd0);

    // START held high: back-to-back conversions of 5.
    repeat (20) step(1'b1, 6'd5);
    repeat (9) step(1'b0, 6'd0);

    // Random operands with random gaps (some STARTs land while busy).
    repeat (30) begin
      step(1'b1, 6'($urandom_range(0, 63)));
      repeat ($urandom_range(0, 9)) step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end
    repeat (12) step(1'b0, 6'd0);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_pending_results", d), sb[d].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
